// File: rtl/nnet_stream_framer.sv
// Width adapter and RFNoC packet framer around an HLS neural-net core.
// Optional input framing check: define NNET_FRAME_CHECK_EN.
module nnet_stream_framer #(
  parameter int SR_SPP      = 131,
  parameter int NNET_W      = 18,
  parameter int SIGN_EXT    = 1,
  parameter int SIZE_W      = 16,
  parameter int SPP_DEFAULT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              set_stb,
  input  logic [7:0]        set_addr,
  input  logic [31:0]       set_data,
  input  logic [15:0]       src_sid,
  input  logic [15:0]       next_dst_sid,
  input  logic [SIZE_W-1:0] nnet_size_in,
  input  logic [SIZE_W-1:0] nnet_size_out,
  input  logic [31:0]       i_tdata,
  input  logic              i_tlast,
  input  logic              i_tvalid,
  output logic              i_tready,
  input  logic [127:0]      i_tuser,
  output logic [31:0]       o_tdata,
  output logic              o_tlast,
  output logic              o_tvalid,
  input  logic              o_tready,
  output logic [127:0]      o_tuser,
  output logic [NNET_W-1:0] m_axis_nnet_tdata,
  output logic              m_axis_nnet_tlast,
  output logic              m_axis_nnet_tvalid,
  input  logic              m_axis_nnet_tready,
  input  logic [NNET_W-1:0] s_axis_nnet_tdata,
  input  logic              s_axis_nnet_tvalid,
  output logic              s_axis_nnet_tready,
  output logic [15:0]       spp_out,
  output logic [31:0]       vec_in_cnt,
  output logic [31:0]       vec_out_cnt,
  output logic              frame_err
);

  localparam logic [7:0]  SPP_ADDR  = 8'(SR_SPP);
  localparam logic [15:0] SPP_RESET = 16'(SPP_DEFAULT);

  function automatic logic [31:0] extend_result(input logic [NNET_W-1:0] d);
    logic [31:0] r;
    r = ((SIGN_EXT != 0) && d[NNET_W-1]) ? '1 : '0;
    r[NNET_W-1:0] = d;
    return r;
  endfunction

  logic [SIZE_W-1:0] in_idx;
  logic [SIZE_W-1:0] size_in_m1;
  logic [SIZE_W-1:0] out_vec_idx;
  logic [SIZE_W-1:0] size_out_m1;
  logic [15:0]       spp;
  logic [15:0]       active_spp;
  logic [15:0]       pkt_spp;
  logic [15:0]       out_pkt_idx;
  logic [63:0]       hdr;
  logic              sop;
  logic              in_acc;
  logic              tlast_nom;
  logic              forced_tlast;
  logic              out_acc;
  logic              pkt_end;
  logic              vec_end;
  logic              unused_bits;

  assign unused_bits = ^{i_tuser[63:0], set_data[31:16], hdr[60]};

  // Input path: pure pass-through with a generated per-vector tlast
  assign size_in_m1         = nnet_size_in - SIZE_W'(1);
  assign tlast_nom          = (nnet_size_in == '0) || (in_idx == size_in_m1);
  assign m_axis_nnet_tdata  = i_tdata[NNET_W-1:0];
  assign m_axis_nnet_tvalid = i_tvalid;
  assign i_tready           = m_axis_nnet_tready;
  assign in_acc             = i_tvalid && m_axis_nnet_tready;

`ifdef NNET_FRAME_CHECK_EN
  logic frame_err_r;

  assign forced_tlast      = i_tlast && !tlast_nom;
  assign m_axis_nnet_tlast = tlast_nom || forced_tlast;
  assign frame_err         = frame_err_r;

  always_ff @(posedge clk) begin
    if (reset || clear)
      frame_err_r <= 1'b0;
    else if (in_acc && forced_tlast)
      frame_err_r <= 1'b1;
  end
`else
  assign forced_tlast      = 1'b0;
  assign m_axis_nnet_tlast = tlast_nom;
  assign frame_err         = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      in_idx <= '0;
      sop    <= 1'b1;
    end else if (in_acc) begin
      in_idx <= m_axis_nnet_tlast ? '0 : in_idx + SIZE_W'(1);
      if (i_tlast)
        sop <= 1'b1;
      else if (sop)
        sop <= 1'b0;
    end
  end

  // A forced tlast is never a nominal vector end, so it is not counted
  always_ff @(posedge clk) begin
    if (reset)
      vec_in_cnt <= '0;
    else if (!clear && in_acc && tlast_nom)
      vec_in_cnt <= vec_in_cnt + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (in_acc && sop)
      hdr <= i_tuser[127:64];
  end

  always_ff @(posedge clk) begin
    if (reset)
      spp <= SPP_RESET;
    else if (set_stb && (set_addr == SPP_ADDR) && (set_data[15:0] != 16'd0))
      spp <= set_data[15:0];
  end

  assign spp_out = spp;

  // Output stage: one register slice, packet bounded by SPP and vector end
  assign s_axis_nnet_tready = !o_tvalid || o_tready;
  assign out_acc            = s_axis_nnet_tvalid && s_axis_nnet_tready;
  assign size_out_m1        = nnet_size_out - SIZE_W'(1);
  assign pkt_spp            = (out_pkt_idx == 16'd0) ? spp : active_spp;
  assign pkt_end            = (out_pkt_idx == pkt_spp - 16'd1);
  assign vec_end            = (nnet_size_out == '0) || (out_vec_idx == size_out_m1);

  always_ff @(posedge clk) begin
    if (reset) begin
      o_tvalid    <= 1'b0;
      o_tdata     <= '0;
      o_tlast     <= 1'b0;
      o_tuser     <= '0;
      out_pkt_idx <= '0;
      out_vec_idx <= '0;
      active_spp  <= SPP_RESET;
    end else if (clear) begin
      o_tvalid    <= 1'b0;
      out_pkt_idx <= '0;
      out_vec_idx <= '0;
    end else if (out_acc) begin
      o_tdata     <= extend_result(s_axis_nnet_tdata);
      o_tvalid    <= 1'b1;
      o_tlast     <= pkt_end || vec_end;
      out_pkt_idx <= (pkt_end || vec_end) ? 16'd0 : out_pkt_idx + 16'd1;
      out_vec_idx <= vec_end ? '0 : out_vec_idx + SIZE_W'(1);
      if (out_pkt_idx == 16'd0) begin
        active_spp <= spp;
        o_tuser    <= {hdr[63:61], 1'b0, hdr[59:48], 16'd0, src_sid, next_dst_sid, 64'd0};
      end
    end else if (o_tready) begin
      o_tvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      vec_out_cnt <= '0;
    else if (!clear && out_acc && vec_end)
      vec_out_cnt <= vec_out_cnt + 32'd1;
  end

endmodule

// File: tb/tb_nnet_stream_framer.sv
// Randomized bench for nnet_stream_framer against a queue-based reference model.
module tb_nnet_stream_framer;

  localparam int NNET_W   = 18;
  localparam int SIGN_EXT = 1;
  localparam int SIZE_W   = 16;
`ifdef NNET_FRAME_CHECK_EN
  localparam bit FC = 1'b1;
`else
  localparam bit FC = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset, clear, set_stb;
  logic [7:0]        set_addr;
  logic [31:0]       set_data;
  logic [15:0]       src_sid, next_dst_sid;
  logic [SIZE_W-1:0] nnet_size_in, nnet_size_out;
  logic [31:0]       i_tdata;
  logic              i_tlast, i_tvalid, i_tready;
  logic [127:0]      i_tuser;
  logic [31:0]       o_tdata;
  logic              o_tlast, o_tvalid, o_tready;
  logic [127:0]      o_tuser;
  logic [NNET_W-1:0] m_tdata;
  logic              m_tlast, m_tvalid, m_tready;
  logic [NNET_W-1:0] s_tdata;
  logic              s_tvalid, s_tready;
  logic [15:0]       spp_out;
  logic [31:0]       vec_in_cnt, vec_out_cnt;
  logic              frame_err;

  always #5 clk = ~clk;

  nnet_stream_framer #(
    .SR_SPP(131), .NNET_W(NNET_W), .SIGN_EXT(SIGN_EXT), .SIZE_W(SIZE_W), .SPP_DEFAULT(64)
  ) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .src_sid(src_sid), .next_dst_sid(next_dst_sid),
    .nnet_size_in(nnet_size_in), .nnet_size_out(nnet_size_out),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
    .i_tuser(i_tuser),
    .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
    .o_tuser(o_tuser),
    .m_axis_nnet_tdata(m_tdata), .m_axis_nnet_tlast(m_tlast),
    .m_axis_nnet_tvalid(m_tvalid), .m_axis_nnet_tready(m_tready),
    .s_axis_nnet_tdata(s_tdata), .s_axis_nnet_tvalid(s_tvalid),
    .s_axis_nnet_tready(s_tready),
    .spp_out(spp_out), .vec_in_cnt(vec_in_cnt), .vec_out_cnt(vec_out_cnt),
    .frame_err(frame_err)
  );

  int n_total = 0;
  int n_bad   = 0;

  // Reference model state
  logic [63:0]       hdr_ref;
  int                m_k, m_nb, m_cnt, m_pkt_spp, m_spp;
  int                exp_vin, exp_vout;
  logic [NNET_W-1:0] dq[$];
  logic [31:0]       exp_d[$];
  logic              exp_l[$];
  int                lastpos[$];
  logic [31:0]       first_out;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    n_total++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [31:0] ref_ext(input logic [NNET_W-1:0] d);
    logic signed [NNET_W-1:0] sd;
    sd = d;
    if (SIGN_EXT != 0) return 32'(sd);
    return 32'(d);
  endfunction

  function automatic logic [127:0] ref_tuser();
    return {hdr_ref[63:61], 1'b0, hdr_ref[59:48], 16'h0000, src_sid, next_dst_sid, 64'h0};
  endfunction

  task automatic clear_pulse();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    m_k = 0; m_nb = 0; m_cnt = 0;
  endtask

  task automatic spp_write(input logic [15:0] v);
    @(negedge clk);
    set_stb  = 1'b1;
    set_addr = 8'd131;
    set_data = {16'($urandom), v};
    @(negedge clk);
    set_stb = 1'b0;
    if (v != 16'd0) m_spp = int'(v);
  endtask

  task automatic in_run(input int n, input int pv, input int pr, input bit directed);
    int acc = 0;
    int cyc = 0;
    int sz;
    logic el;
    sz = int'(nnet_size_in);
    while (acc < n && cyc < 2000) begin
      @(negedge clk);
      i_tvalid = ($urandom_range(99) < pv);
      m_tready = ($urandom_range(99) < pr);
      i_tdata  = directed ? ((acc == 0) ? 32'h0003FFFF : 32'(acc)) : $urandom;
      el       = (sz == 0) || ((m_k % sz) == sz - 1);
      i_tlast  = el;
      #1;
      chk("in_ready", i_tready, m_tready);
      chk("in_valid", m_tvalid, i_tvalid);
      if (i_tvalid && i_tready) begin
        chk("in_tlast", m_tlast, el);
        chk("in_tdata", m_tdata, i_tdata[NNET_W-1:0]);
        if (directed && acc == 0) chk("in_tdata18", m_tdata, 18'h3FFFF);
        if (el) exp_vin++;
        m_k++;
        acc++;
      end
      cyc++;
    end
    if (acc < n) chk("in_timeout", acc, n);
    @(negedge clk);
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
  endtask

  task automatic out_run(input int n, input int pv, input int pr, input int wr_at,
                         input logic [15:0] wr_val, input int stall_at);
    int sent = 0;
    int recvd = 0;
    int cyc = 0;
    int stall_cnt = 0;
    bit wr_done = 1'b0;
    bit hold_v = 1'b0;
    logic [31:0] hold_d;
    logic hold_l;
    bit vend, last;
    lastpos.delete();
    while (recvd < n && cyc < 3000) begin
      @(negedge clk);
      if (sent < n) begin
        s_tvalid = ($urandom_range(99) < pv);
        s_tdata  = dq[sent];
      end else begin
        s_tvalid = 1'b0;
      end
      if (stall_at >= 0 && recvd == stall_at && stall_cnt < 5) begin
        o_tready = 1'b0;
        stall_cnt++;
      end else begin
        o_tready = ($urandom_range(99) < pr);
      end
      set_stb  = (sent == wr_at) && !wr_done;
      set_addr = 8'd131;
      set_data = {16'($urandom), wr_val};
      #1;
      if (hold_v) begin
        chk("hold_vld", o_tvalid, 1'b1);
        chk("hold_data", o_tdata, hold_d);
        chk("hold_last", o_tlast, hold_l);
      end
      if (o_tvalid && !o_tready) chk("bp_ready", s_tready, 1'b0);
      hold_v = o_tvalid && !o_tready;
      hold_d = o_tdata;
      hold_l = o_tlast;
      if (o_tvalid && o_tready) begin
        if (exp_d.size() == 0) begin
          chk("out_extra", recvd, n);
        end else begin
          chk("out_data", o_tdata, exp_d.pop_front());
          chk("out_last", o_tlast, exp_l.pop_front());
          chk("out_tuser", o_tuser, ref_tuser());
          if (recvd == 0) first_out = o_tdata;
          if (o_tlast) lastpos.push_back(recvd);
        end
        recvd++;
      end
      if (s_tvalid && s_tready) begin
        if (m_cnt == 0) m_pkt_spp = m_spp;
        vend = (nnet_size_out == '0) || ((m_nb % int'(nnet_size_out)) == int'(nnet_size_out) - 1);
        last = vend || (m_cnt + 1 == m_pkt_spp);
        exp_d.push_back(ref_ext(s_tdata));
        exp_l.push_back(last);
        m_cnt = last ? 0 : m_cnt + 1;
        m_nb++;
        if (vend) exp_vout++;
        sent++;
      end
      if (set_stb) begin
        wr_done = 1'b1;
        if (wr_val != 16'd0) m_spp = int'(wr_val);
      end
      cyc++;
    end
    if (recvd < n) chk("out_timeout", recvd, n);
    @(negedge clk);
    s_tvalid = 1'b0;
    o_tready = 1'b1;
    set_stb  = 1'b0;
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; set_stb = 1'b0; set_addr = '0; set_data = '0;
    src_sid = 16'($urandom); next_dst_sid = 16'($urandom);
    nnet_size_in = 16'd4; nnet_size_out = 16'd5;
    i_tdata = '0; i_tlast = 1'b0; i_tvalid = 1'b0;
    hdr_ref = {$urandom, $urandom};
    hdr_ref[60] = 1'b1;
    i_tuser = {hdr_ref, $urandom, $urandom};
    o_tready = 1'b1; m_tready = 1'b1; s_tdata = '0; s_tvalid = 1'b0;
    m_k = 0; m_nb = 0; m_cnt = 0; m_pkt_spp = 64; m_spp = 64;
    exp_vin = 0; exp_vout = 0; first_out = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_ovalid", o_tvalid, 1'b0);
    chk("rst_odata", o_tdata, 32'h0);
    chk("rst_olast", o_tlast, 1'b0);
    chk("rst_otuser", o_tuser, 128'h0);
    chk("rst_spp", spp_out, 16'd64);
    chk("rst_ferr", frame_err, 1'b0);
    chk("rst_vin", vec_in_cnt, 32'd0);
    chk("rst_vout", vec_out_cnt, 32'd0);

    // Input framing, directed then randomized vector sizes
    in_run(8, 100, 100, 1'b1);
    chk("vin_directed", vec_in_cnt, 32'd2);
    for (int t = 0; t < 4; t++) begin
      clear_pulse();
      nnet_size_in = 16'($urandom_range(6));
      in_run(30, 70, 70, 1'b0);
      chk("vin_rand", vec_in_cnt, exp_vin);
    end

    // Early i_tlast on beat 3 of a 4-beat vector
    clear_pulse();
    nnet_size_in = 16'd4;
    m_tready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      i_tvalid = 1'b1;
      i_tdata  = $urandom;
      i_tlast  = (b == 2);
      #1;
      if (b == 2) chk("fc_beat3_tlast", m_tlast, FC);
      if (b == 3) chk("fc_beat4_tlast", m_tlast, !FC);
    end
    if (!FC) exp_vin++;
    @(negedge clk);
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
    #1;
    chk("fc_err", frame_err, FC);
    chk("fc_vin", vec_in_cnt, exp_vin);
    clear_pulse();
    #1;
    chk("fc_clear", frame_err, 1'b0);

    // Sign extension and dual framing: spp=3, vector=5
    spp_write(16'd3);
    chk("spp3", spp_out, 16'd3);
    nnet_size_out = 16'd5;
    dq.delete();
    dq.push_back(18'h20000);
    dq.push_back(18'h1FFFF);
    dq.push_back(18'h3FFFF);
    for (int i = 0; i < 7; i++) dq.push_back(NNET_W'($urandom));
    out_run(10, 100, 100, -1, 16'd0, -1);
    chk("sext", first_out, 32'hFFFE0000);
    chk("dual_nlast", lastpos.size(), 4);
    if (lastpos.size() == 4) begin
      chk("dual_pos0", lastpos[0], 2);
      chk("dual_pos1", lastpos[1], 4);
      chk("dual_pos2", lastpos[2], 7);
      chk("dual_pos3", lastpos[3], 9);
    end
    chk("vout_dual", vec_out_cnt, 32'd2);

    // Backpressure mid-packet plus SPP change to 2
    clear_pulse();
    nnet_size_out = 16'd100;
    dq.delete();
    for (int i = 0; i < 7; i++) dq.push_back(NNET_W'($urandom));
    out_run(7, 100, 100, 1, 16'd2, 1);
    chk("sppchg_nlast", lastpos.size(), 3);
    if (lastpos.size() == 3) begin
      chk("sppchg_pos0", lastpos[0], 2);
      chk("sppchg_pos1", lastpos[1], 4);
      chk("sppchg_pos2", lastpos[2], 6);
    end
    spp_write(16'd0);
    chk("spp_zero_ignored", spp_out, 16'd2);

    // Randomized output framing with SPP writes at random points
    for (int t = 0; t < 5; t++) begin
      clear_pulse();
      nnet_size_out = 16'($urandom_range(7));
      dq.delete();
      for (int i = 0; i < 40; i++) dq.push_back(NNET_W'($urandom));
      out_run(40, 60, 60, int'($urandom_range(39)), 16'($urandom_range(4)), -1);
      chk("vout_rand", vec_out_cnt, exp_vout);
      chk("spp_rand", spp_out, m_spp);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
